// File: rtl/mips_multicycle_control.sv
// Main control sequencer for the multi-cycle MIPS datapath.
// Moore FSM: datapath controls are decoded from the current state. The only
// exceptions are the FETCH strobes gated by mem_ready, and the reset gating
// of all write/read strobes.
module mips_multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
    S_HALT   = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halted_q, halted_d;
  logic             retire;

  // Next-state, retire detection and sticky halt flag.
  always_comb begin
    state_d = S_FETCH;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_HALT;
        endcase
      end
      // Only lw/sw reach MEMADR; anything but sw is treated as lw.
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  begin state_d = S_FETCH; retire = 1'b1; end
      S_MEMWR:  begin
        state_d = mem_ready ? S_FETCH : S_MEMWR;
        retire  = mem_ready;
      end
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  begin state_d = S_FETCH; retire = 1'b1; end
      S_BRANCH: begin state_d = S_FETCH; retire = 1'b1; end
      S_JUMP:   begin state_d = S_FETCH; retire = 1'b1; end
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: begin state_d = S_FETCH; retire = 1'b1; end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
    cnt_d    = retire ? cnt_q + 1'b1 : cnt_q;
    halted_d = halted_q | (state_d == S_HALT);
  end

  // State, retired-instruction counter and halt flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
    end
  end

  logic pc_write_s, pc_write_cond_s, mem_read_s, mem_write_s, ir_write_s, reg_write_s;

  // Moore output decode; strobes are masked while reset is held.
  always_comb begin
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    mem_read_s      = 1'b0;
    mem_write_s     = 1'b0;
    ir_write_s      = 1'b0;
    reg_write_s     = 1'b0;
    i_or_d          = 1'b0;
    reg_dst         = 1'b0;
    mem_to_reg      = 1'b0;
    alu_src_a       = 1'b0;
    alu_src_b       = 2'b00;
    alu_op          = 2'b00;
    pc_source       = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_read_s = 1'b1;
        alu_src_b  = 2'b01;
        ir_write_s = mem_ready;
        pc_write_s = mem_ready;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read_s = 1'b1;
        i_or_d     = 1'b1;
      end
      S_MEMWB: begin
        reg_write_s = 1'b1;
        mem_to_reg  = 1'b1;
      end
      S_MEMWR: begin
        mem_write_s = 1'b1;
        i_or_d      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
        reg_dst     = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a       = 1'b1;
        alu_op          = 2'b01;
        pc_write_cond_s = 1'b1;
        pc_source       = 2'b01;
      end
      S_JUMP: begin
        pc_write_s = 1'b1;
        pc_source  = 2'b10;
      end
      S_ADDIWB: reg_write_s = 1'b1;
      default: ;
    endcase
    pc_write      = pc_write_s      & rst_n;
    pc_write_cond = pc_write_cond_s & rst_n;
    mem_read      = mem_read_s      & rst_n;
    mem_write     = mem_write_s     & rst_n;
    ir_write      = ir_write_s      & rst_n;
    reg_write     = reg_write_s     & rst_n;
  end

  assign state       = state_q;
  assign halted      = halted_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed, table-driven bench for mips_multicycle_control.
// Control word packing (bit 15 down to 0):
// pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_dst,
// mem_to_reg, reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_source[1:0]
module tb_mips_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b1;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state;
  logic        halted;
  logic [31:0] instr_count;

  mips_multicycle_control #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .halted(halted), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  logic [15:0] ctrl;
  assign ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                 reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

  // Hand-computed control words per state
  localparam logic [15:0] C_RST    = 16'h0010;
  localparam logic [15:0] C_FETCH  = 16'h9410;
  localparam logic [15:0] C_FSTALL = 16'h1010;
  localparam logic [15:0] C_DEC    = 16'h0030;
  localparam logic [15:0] C_MEMADR = 16'h0060;
  localparam logic [15:0] C_MEMRD  = 16'h3000;
  localparam logic [15:0] C_MEMWB  = 16'h0180;
  localparam logic [15:0] C_MEMWR  = 16'h2800;
  localparam logic [15:0] C_EXEC   = 16'h0048;
  localparam logic [15:0] C_ALUWB  = 16'h0280;
  localparam logic [15:0] C_BRANCH = 16'h4045;
  localparam logic [15:0] C_JUMP   = 16'h8002;
  localparam logic [15:0] C_ADDIEX = 16'h0060;
  localparam logic [15:0] C_ADDIWB = 16'h0080;
  localparam logic [15:0] C_HALT   = 16'h0000;

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000, ILL = 6'b111111;

  typedef struct {
    logic        rst_n;
    logic [5:0]  opcode;
    logic        zero;
    logic        rdy;
    logic [3:0]  st;
    logic [15:0] ctl;
    logic        hlt;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic [5:0] op, input logic z, input logic rdy,
                     input logic [3:0] st, input logic [15:0] ctl, input logic hlt,
                     input logic [31:0] cnt);
    vec_t v;
    v.rst_n = r; v.opcode = op; v.zero = z; v.rdy = rdy;
    v.st = st; v.ctl = ctl; v.hlt = hlt; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  // Drive inputs away from the active edge, then check the current cycle.
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    rst_n = v.rst_n; opcode = v.opcode; zero = v.zero; mem_ready = v.rdy;
    #1;
    chk($sformatf("v%0d state", idx), {28'd0, state}, {28'd0, v.st});
    chk($sformatf("v%0d ctrl", idx), {16'd0, ctrl}, {16'd0, v.ctl});
    chk($sformatf("v%0d halted", idx), {31'd0, halted}, {31'd0, v.hlt});
    chk($sformatf("v%0d count", idx), instr_count, v.cnt);
  endtask

  initial begin
    // Reset, then R-type
    add(0, R,   0, 1, 0,  C_RST,    0, 0);
    add(1, R,   0, 1, 0,  C_FETCH,  0, 0);
    add(1, R,   0, 1, 1,  C_DEC,    0, 0);
    add(1, R,   0, 1, 6,  C_EXEC,   0, 0);
    add(1, R,   0, 1, 7,  C_ALUWB,  0, 0);
    // lw with two stall cycles in MEMRD
    add(1, LW,  0, 1, 0,  C_FETCH,  0, 1);
    add(1, LW,  0, 1, 1,  C_DEC,    0, 1);
    add(1, LW,  0, 1, 2,  C_MEMADR, 0, 1);
    add(1, LW,  0, 0, 3,  C_MEMRD,  0, 1);
    add(1, LW,  0, 0, 3,  C_MEMRD,  0, 1);
    add(1, LW,  0, 1, 3,  C_MEMRD,  0, 1);
    add(1, LW,  0, 1, 4,  C_MEMWB,  0, 1);
    // FETCH stall, then beq with zero=1
    add(1, BEQ, 1, 0, 0,  C_FSTALL, 0, 2);
    add(1, BEQ, 1, 1, 0,  C_FETCH,  0, 2);
    add(1, BEQ, 1, 1, 1,  C_DEC,    0, 2);
    add(1, BEQ, 1, 1, 8,  C_BRANCH, 0, 2);
    // j then addi
    add(1, J,   0, 1, 0,  C_FETCH,  0, 3);
    add(1, J,   0, 1, 1,  C_DEC,    0, 3);
    add(1, J,   0, 1, 9,  C_JUMP,   0, 3);
    add(1, ADDI,0, 1, 0,  C_FETCH,  0, 4);
    add(1, ADDI,0, 1, 1,  C_DEC,    0, 4);
    add(1, ADDI,0, 1, 10, C_ADDIEX, 0, 4);
    add(1, ADDI,0, 1, 11, C_ADDIWB, 0, 4);
    // sw; mem_ready low in DECODE must be ignored
    add(1, SW,  0, 1, 0,  C_FETCH,  0, 5);
    add(1, SW,  0, 0, 1,  C_DEC,    0, 5);
    add(1, SW,  0, 1, 2,  C_MEMADR, 0, 5);
    add(1, SW,  0, 1, 5,  C_MEMWR,  0, 5);
    // illegal opcode
    add(1, ILL, 0, 1, 0,  C_FETCH,  0, 6);
    add(1, ILL, 0, 1, 1,  C_DEC,    0, 6);
    add(1, ILL, 0, 1, 12, C_HALT,   1, 6);

    #2;
    foreach (vecs[i]) apply(vecs[i], i);

    // HALT is sticky for 20 cycles regardless of mem_ready
    for (int i = 0; i < 20; i++) begin
      vec_t v;
      v.rst_n = 1; v.opcode = (i % 2 == 0) ? ILL : R; v.zero = 0; v.rdy = i[0];
      v.st = 12; v.ctl = C_HALT; v.hlt = 1; v.cnt = 6;
      apply(v, 100 + i);
    end

    // Mid-cycle reset clears halt
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("halt_rst state", {28'd0, state}, 32'd0);
    chk("halt_rst halted", {31'd0, halted}, 32'd0);
    chk("halt_rst count", instr_count, 32'd0);
    chk("halt_rst ctrl", {16'd0, ctrl}, {16'd0, C_RST});

    // sw stalls in MEMWR, then reset mid-stall
    vecs.delete();
    add(1, SW, 0, 1, 0, C_FETCH,  0, 0);
    add(1, SW, 0, 1, 1, C_DEC,    0, 0);
    add(1, SW, 0, 1, 2, C_MEMADR, 0, 0);
    add(1, SW, 0, 0, 5, C_MEMWR,  0, 0);
    add(1, SW, 0, 0, 5, C_MEMWR,  0, 0);
    foreach (vecs[i]) apply(vecs[i], 200 + i);

    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("stall mem_write", {31'd0, mem_write}, 32'd1);
    chk("stall state", {28'd0, state}, 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("wr_rst mem_write", {31'd0, mem_write}, 32'd0);
    chk("wr_rst state", {28'd0, state}, 32'd0);
    chk("wr_rst count", instr_count, 32'd0);

    // After release: R-type must not produce any write strobe, then a new sw
    vecs.delete();
    add(0, R,  0, 0, 0, C_RST,    0, 0);
    add(1, R,  0, 1, 0, C_FETCH,  0, 0);
    add(1, R,  0, 1, 1, C_DEC,    0, 0);
    add(1, R,  0, 1, 6, C_EXEC,   0, 0);
    add(1, R,  0, 1, 7, C_ALUWB,  0, 0);
    add(1, SW, 0, 1, 0, C_FETCH,  0, 1);
    add(1, SW, 0, 1, 1, C_DEC,    0, 1);
    add(1, SW, 0, 1, 2, C_MEMADR, 0, 1);
    add(1, SW, 0, 1, 5, C_MEMWR,  0, 1);
    add(1, R,  0, 1, 0, C_FETCH,  0, 2);
    foreach (vecs[i]) apply(vecs[i], 300 + i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
